// File: rtl/reg_readout.sv
// Snapshots one register of a bank on request and serializes it MSB-first with a per-bit strobe.
// Outputs decode registered state only; requests arriving while busy are dropped, not queued.
module reg_readout #(
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int CLK_DIV  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req,
    input  logic [ADDR_W-1:0]     rd_addr,
    input  logic [8*NUM_REGS-1:0] regs_flat,
    output logic                  busy,
    output logic                  rd_ack,
    output logic                  err,
    output logic                  frame,
    output logic                  sdo,
    output logic                  bit_stb,
    output logic                  done
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state, state_nxt;
    logic [7:0]     shreg, shreg_nxt;
    logic [2:0]     cnt, cnt_nxt;
    logic [DW-1:0]  div, div_nxt;
    logic           ack_q, ack_nxt;
    logic           err_q, err_nxt;
    logic [7:0]     sel_reg;
    logic           addr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            div   <= '0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
            div   <= div_nxt;
            ack_q <= ack_nxt;
            err_q <= err_nxt;
        end
    end

    always_comb begin
        addr_ok = 32'(rd_addr) < 32'(NUM_REGS);
        sel_reg = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(rd_addr) == 32'(i)) sel_reg = regs_flat[8*i +: 8];
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        div_nxt   = div;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                // err_q marks the one busy cycle after a rejected address
                if (rd_req && !err_q) begin
                    ack_nxt = 1'b1;
                    if (addr_ok) begin
                        shreg_nxt = sel_reg;
                        cnt_nxt   = 3'd7;
                        div_nxt   = '0;
                        state_nxt = SHIFT;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (div == DW'(CLK_DIV - 1)) begin
                    div_nxt   = '0;
                    shreg_nxt = {shreg[6:0], 1'b0};
                    if (cnt == 3'd0) state_nxt = DONE;
                    else             cnt_nxt   = cnt - 3'd1;
                end else begin
                    div_nxt = div + DW'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE) || err_q;
        rd_ack  = ack_q;
        err     = err_q;
        frame   = (state == SHIFT);
        sdo     = (state == SHIFT) && shreg[7];
        bit_stb = (state == SHIFT) && (div == '0);
        done    = (state == DONE);
    end

endmodule

// File: tb/tb_reg_readout.sv
// Bench for reg_readout: table vectors, hand sequences for multi-cycle corners, random reads vs a frame model.
module tb_reg_readout;
    localparam int D = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rd_req, sel;
    logic [1:0]  rd_addr;
    logic [31:0] regs4;
    logic [23:0] regs3;
    logic        req4, req3;
    logic        busy4, ack4, err4, frame4, sdo4, stb4, done4;
    logic        busy3, ack3, err3, frame3, sdo3, stb3, done3;
    logic [6:0]  obs;

    assign req4 = rd_req & ~sel;
    assign req3 = rd_req & sel;
    // obs = {busy, rd_ack, err, frame, sdo, bit_stb, done}
    assign obs = sel ? {busy3, ack3, err3, frame3, sdo3, stb3, done3}
                     : {busy4, ack4, err4, frame4, sdo4, stb4, done4};

    reg_readout #(.NUM_REGS(4), .ADDR_W(2), .CLK_DIV(D)) u_dut4 (
        .clk(clk), .rst(rst), .rd_req(req4), .rd_addr(rd_addr), .regs_flat(regs4),
        .busy(busy4), .rd_ack(ack4), .err(err4), .frame(frame4), .sdo(sdo4),
        .bit_stb(stb4), .done(done4)
    );

    reg_readout #(.NUM_REGS(3), .ADDR_W(2), .CLK_DIV(D)) u_dut3 (
        .clk(clk), .rst(rst), .rd_req(req3), .rd_addr(rd_addr), .regs_flat(regs3),
        .busy(busy3), .rd_ack(ack3), .err(err3), .frame(frame3), .sdo(sdo3),
        .bit_stb(stb3), .done(done3)
    );

    typedef struct {
        logic       sel;
        logic [1:0] addr;
        logic [7:0] byte_exp;
        logic       err_exp;
        int         kind;    // 0 plain, 1 rd_req while busy, 2 snapshot, 3 reset mid-frame
        int         poke_t;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected outputs t cycles after the rd_ack cycle for a frame carrying b
    function automatic logic [6:0] model_out(input int t, input logic [7:0] b);
        logic in_frame;
        logic bit_v;
        in_frame = (t < 8*D);
        bit_v    = in_frame ? b[7 - t/D] : 1'b0;
        return {t <= 8*D, t == 0, 1'b0, in_frame, bit_v, in_frame && (t % D == 0), t == 8*D};
    endfunction

    task automatic capture(input logic [7:0] exp, input int kind, input int poke_t, input string name);
        int         bad  = 0;
        int         nstb = 0;
        int         late = 0;
        logic [7:0] got  = 8'h00;
        for (int t = 0; t <= 8*D + 1; t++) begin
            if (obs !== model_out(t, exp)) bad++;
            if (obs[1]) begin
                got = {got[6:0], obs[2]};
                nstb++;
            end
            if (t == poke_t) begin
                if (kind == 1) begin
                    rd_req  = 1'b1;
                    rd_addr = 2'd1;
                end else if (kind == 2) begin
                    regs4[15:8] = 8'hF0;
                end else if (kind == 3) begin
                    rst = 1'b1;
                    tick;
                    rst = 1'b0;
                    chk({name, "_rst_zero"}, 32'(obs), 32'h0);
                    for (int i = 0; i < 8*D; i++) begin
                        tick;
                        if (obs !== 7'h00) late++;
                    end
                    chk({name, "_pre_wave"}, 32'(bad), 32'h0);
                    chk({name, "_no_done"}, 32'(late), 32'h0);
                    return;
                end
            end
            tick;
            if (kind == 1 && t == poke_t) rd_req = 1'b0;
        end
        chk({name, "_wave"}, 32'(bad), 32'h0);
        chk({name, "_byte"}, 32'(got), 32'(exp));
        chk({name, "_nstb"}, 32'(nstb), 32'd8);
    endtask

    task automatic run(input vec_t v, input string name);
        if (v.kind == 2) regs4[15:8] = 8'h0F;
        sel     = v.sel;
        rd_addr = v.addr;
        rd_req  = 1'b1;
        tick;
        rd_req  = 1'b0;
        if (v.err_exp) begin
            chk({name, "_err_pulse"}, 32'(obs), 32'h70);
            tick;
            chk({name, "_err_after"}, 32'(obs), 32'h0);
        end else begin
            capture(v.byte_exp, v.kind, v.poke_t, name);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t       tv[6];
        string      tn[6];
        logic [7:0] m[4];
        vec_t       rv;

        tv[0] = '{1'b0, 2'd2, 8'hA5, 1'b0, 0, -1};  tn[0] = "basic";
        tv[1] = '{1'b0, 2'd1, 8'h81, 1'b0, 1, 10};  tn[1] = "busy_ign";
        tv[2] = '{1'b0, 2'd1, 8'h0F, 1'b0, 2, 9};   tn[2] = "snapshot";
        tv[3] = '{1'b1, 2'd3, 8'h00, 1'b1, 0, -1};  tn[3] = "invalid";
        tv[4] = '{1'b1, 2'd2, 8'h5A, 1'b0, 0, -1};  tn[4] = "dut3_valid";
        tv[5] = '{1'b0, 2'd2, 8'hA5, 1'b0, 3, 17};  tn[5] = "rst_mid";

        rst     = 1'b1;
        rd_req  = 1'b0;
        rd_addr = 2'd0;
        sel     = 1'b0;
        regs4   = {8'hFF, 8'hA5, 8'h81, 8'h3C};
        regs3   = {8'h5A, 8'h22, 8'h11};
        repeat (3) tick;
        chk("reset4", 32'(obs), 32'h0);
        sel = 1'b1;
        #1;
        chk("reset3", 32'(obs), 32'h0);
        sel = 1'b0;
        rst = 1'b0;
        tick;

        for (int i = 0; i < 6; i++) begin
            run(tv[i], tn[i]);
            tick;
        end

        run(tv[0], "after_rst");

        // Back-to-back with rd_req held high
        sel     = 1'b0;
        rd_addr = 2'd0;
        rd_req  = 1'b1;
        tick;
        rd_addr = 2'd3;
        capture(8'h3C, 4, -1, "b2b1");
        chk("b2b_gap_ack", 32'(obs[5]), 32'h1);
        rd_req = 1'b0;
        capture(8'hFF, 0, -1, "b2b2");

        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < 4; k++) m[k] = 8'($urandom);
            regs4      = {m[3], m[2], m[1], m[0]};
            regs3      = {m[2], m[1], m[0]};
            rv.sel     = 1'($urandom_range(0, 1));
            rv.addr    = 2'($urandom_range(0, 3));
            rv.err_exp = rv.sel && (rv.addr >= 2'd3);
            rv.byte_exp = m[rv.addr];
            rv.kind    = 0;
            rv.poke_t  = -1;
            run(rv, $sformatf("rand%0d", n));
            if ($urandom_range(0, 1) == 1) tick;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
